// File: rtl/dual_issue_scheduler_pkg.sv
// Shared definitions for the dual-issue scheduler: MIPS opcode constants,
// instruction field positions and the scheduler FSM state encoding.
package dual_issue_scheduler_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_MUL   = 6'b011100;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_SPLIT = 1'b1
  } sched_state_t;

endpackage

// File: rtl/dual_issue_scheduler_if.sv
// Fetch-to-scheduler pair handshake: IF (master) presents an I/R instruction
// pair, the scheduler (slave) answers with if_ready when it consumes it.
interface dual_issue_scheduler_if;
  logic        if_valid;
  logic        if_ready;
  logic        if_type_i;
  logic [31:0] if_instr_i;
  logic        if_type_r;
  logic [31:0] if_instr_r;

  modport master (
    output if_valid, if_type_i, if_instr_i, if_type_r, if_instr_r,
    input  if_ready
  );

  modport slave (
    input  if_valid, if_type_i, if_instr_i, if_type_r, if_instr_r,
    output if_ready
  );
endinterface

// File: rtl/dual_issue_scheduler_issue_hazard_detect.sv
// Combinational hazard flags for an I/R instruction pair: RAW and WAW between
// the slots, and load-use against the load currently in EX. Empty slots and
// register 0 never contribute a hazard.
module issue_hazard_detect
  import dual_issue_scheduler_pkg::*;
(
  input  logic       type_i,
  input  logic [5:0] op_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  input  logic       type_r,
  input  logic [4:0] rs_r,
  input  logic [4:0] rt_r,
  input  logic [4:0] rd_r,
  input  logic       ex_memread,
  input  logic [4:0] ex_write_reg,
  output logic       raw,
  output logic       waw,
  output logic       load_use
);

  logic [4:0] i_dst, i_src0, i_src1, r_dst, r_src0, r_src1;

  // Slot decode to source/destination registers, then hazard compares
  always_comb begin
    i_dst  = 5'd0;
    i_src0 = 5'd0;
    i_src1 = 5'd0;
    r_dst  = 5'd0;
    r_src0 = 5'd0;
    r_src1 = 5'd0;
    if (type_i) begin
      i_src0 = rs_i;
      if (op_i == OP_RTYPE || op_i == OP_LW || op_i == OP_MUL)
        i_dst = rt_i;
      if (op_i == OP_SW || op_i == OP_BEQ || op_i == OP_BNE)
        i_src1 = rt_i;
    end
    if (type_r) begin
      r_src0 = rs_r;
      r_src1 = rt_r;
      r_dst  = rd_r;
    end
    raw = (i_dst != 5'd0) && ((i_dst == r_src0) || (i_dst == r_src1));
    waw = (i_dst != 5'd0) && (i_dst == r_dst);
    load_use = ex_memread && (ex_write_reg != 5'd0) &&
               ((ex_write_reg == i_src0) || (ex_write_reg == i_src1) ||
                (ex_write_reg == r_src0) || (ex_write_reg == r_src1));
  end

endmodule

// File: rtl/dual_issue_scheduler.sv
// Dual-issue scheduler between IF/ID and ID: issues a fetched pair together,
// splits it over two cycles on RAW/WAW, bubbles on load-use, drops held work
// on flush and counts stall cycles (saturating).
// Build option: define ISSUE_SERIAL_EN to split every fully occupied pair.
module dual_issue_scheduler
  import dual_issue_scheduler_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 btnc_i,
  dual_issue_scheduler_if.slave fe,
  input  logic                 ex_memread,
  input  logic [4:0]           ex_write_reg,
  input  logic                 flush,
  output logic                 id_type_i,
  output logic [31:0]          id_instr_i,
  output logic                 id_type_r,
  output logic [31:0]          id_instr_r,
  output logic [CNT_W-1:0]     stall_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  sched_state_t     state_p0, state_nx;
  logic             hold_vld_p0;
  logic [31:0]      hold_instr_p0;
  logic             vld_i_p1, vld_r_p1;
  logic [31:0]      instr_i_p1, instr_r_p1;
  logic [CNT_W-1:0] cnt_p1;

  logic             det_type_i, det_type_r;
  logic [31:0]      det_instr_i, det_instr_r;
  logic             raw, waw, load_use, split_req;

  logic             ready_c, nx_vld_i, nx_vld_r, hold_load, hold_clear, cnt_inc;
  logic [31:0]      nx_instr_i, nx_instr_r;

  // Hazard inputs: the fetched pair in RUN, only the held R-slot in SPLIT
  always_comb begin
    det_type_i  = fe.if_type_i;
    det_instr_i = fe.if_instr_i;
    det_type_r  = fe.if_type_r;
    det_instr_r = fe.if_instr_r;
    if (state_p0 == ST_SPLIT) begin
      det_type_i  = 1'b0;
      det_type_r  = hold_vld_p0;
      det_instr_r = hold_instr_p0;
    end
  end

  issue_hazard_detect u_hazard (
    .type_i       (det_type_i),
    .op_i         (det_instr_i[OP_HI:OP_LO]),
    .rs_i         (det_instr_i[RS_HI:RS_LO]),
    .rt_i         (det_instr_i[RT_HI:RT_LO]),
    .type_r       (det_type_r),
    .rs_r         (det_instr_r[RS_HI:RS_LO]),
    .rt_r         (det_instr_r[RT_HI:RT_LO]),
    .rd_r         (det_instr_r[RD_HI:RD_LO]),
    .ex_memread   (ex_memread),
    .ex_write_reg (ex_write_reg),
    .raw          (raw),
    .waw          (waw),
    .load_use     (load_use)
  );

`ifdef ISSUE_SERIAL_EN
  assign split_req = fe.if_type_i & fe.if_type_r;
`else
  assign split_req = raw | waw;
`endif

  // Next-state and issue decision; anything not issued becomes a bubble
  always_comb begin
    state_nx   = state_p0;
    ready_c    = 1'b0;
    nx_vld_i   = 1'b0;
    nx_vld_r   = 1'b0;
    nx_instr_i = instr_i_p1;
    nx_instr_r = instr_r_p1;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    cnt_inc    = 1'b0;
    unique case (state_p0)
      ST_RUN: begin
        if (flush || !fe.if_valid) begin
          ready_c = 1'b0;
        end else if (load_use) begin
          cnt_inc = 1'b1;
        end else if (split_req) begin
          ready_c    = 1'b1;
          nx_vld_i   = fe.if_type_i;
          nx_instr_i = fe.if_instr_i;
          hold_load  = 1'b1;
          cnt_inc    = 1'b1;
          state_nx   = ST_SPLIT;
        end else begin
          ready_c    = 1'b1;
          nx_vld_i   = fe.if_type_i;
          nx_instr_i = fe.if_instr_i;
          nx_vld_r   = fe.if_type_r;
          nx_instr_r = fe.if_instr_r;
        end
      end
      ST_SPLIT: begin
        if (flush) begin
          hold_clear = 1'b1;
          state_nx   = ST_RUN;
        end else if (load_use) begin
          cnt_inc = 1'b1;
        end else begin
          nx_vld_r   = hold_vld_p0;
          nx_instr_r = hold_instr_p0;
          hold_clear = 1'b1;
          state_nx   = ST_RUN;
        end
      end
      default: state_nx = ST_RUN;
    endcase
  end

  assign fe.if_ready = ready_c & ~btnc_i;

  // State, hold register, ID-facing registers and stall counter
  always_ff @(posedge clk) begin
    if (btnc_i) begin
      state_p0    <= ST_RUN;
      hold_vld_p0 <= 1'b0;
      vld_i_p1    <= 1'b0;
      vld_r_p1    <= 1'b0;
      instr_i_p1  <= 32'd0;
      instr_r_p1  <= 32'd0;
      cnt_p1      <= '0;
    end else begin
      state_p0   <= state_nx;
      vld_i_p1   <= nx_vld_i;
      vld_r_p1   <= nx_vld_r;
      instr_i_p1 <= nx_instr_i;
      instr_r_p1 <= nx_instr_r;
      if (hold_load)
        hold_vld_p0 <= 1'b1;
      else if (hold_clear)
        hold_vld_p0 <= 1'b0;
      if (cnt_inc)
        cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  // Hold data carries no reset; its valid bit alone marks it live
  always_ff @(posedge clk) begin
    if (hold_load)
      hold_instr_p0 <= fe.if_instr_r;
  end

  assign id_type_i  = vld_i_p1;
  assign id_instr_i = instr_i_p1;
  assign id_type_r  = vld_r_p1;
  assign id_instr_r = instr_r_p1;
  assign stall_cnt  = cnt_p1;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Self-checking bench for dual_issue_scheduler (default build).
module tb_dual_issue_scheduler;

  localparam logic [31:0] P_I   = 32'h8C220000; // lw  $2,0($1)
  localparam logic [31:0] P_R   = 32'h00A43020; // add $6,$5,$4
  localparam logic [31:0] RAW_R = 32'h00441820; // add $3,$2,$4
  localparam logic [31:0] WAW_I = 32'h70E30000; // op 011100 rs=7 rt=3
  localparam logic [31:0] WAW_R = 32'h01091820; // add $3,$8,$9

  logic        clk = 1'b0;
  logic        btnc_i;
  logic        ex_memread;
  logic [4:0]  ex_write_reg;
  logic        flush;
  logic        id_type_i, id_type_r;
  logic [31:0] id_instr_i, id_instr_r;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  dual_issue_scheduler_if fe ();

  dual_issue_scheduler #(.CNT_W(16)) dut (
    .clk          (clk),
    .btnc_i       (btnc_i),
    .fe           (fe),
    .ex_memread   (ex_memread),
    .ex_write_reg (ex_write_reg),
    .flush        (flush),
    .id_type_i    (id_type_i),
    .id_instr_i   (id_instr_i),
    .id_type_r    (id_type_r),
    .id_instr_r   (id_instr_r),
    .stall_cnt    (stall_cnt)
  );

  typedef struct {
    logic        v, ti, tr, mr, fl;
    logic [31:0] ii, ir;
    logic [4:0]  wr;
    logic        e_rdy, e_ti, e_tr;
    logic [31:0] e_ii, e_ir;
    logic [15:0] e_cnt;
  } vec_t;

  typedef struct {
    logic        ti, tr;
    logic [31:0] ii, ir;
    logic [15:0] cnt;
    int          tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(logic v, logic ti, logic [31:0] ii, logic tr,
                              logic [31:0] ir, logic mr, logic [4:0] wr, logic fl,
                              logic e_rdy, logic e_ti, logic [31:0] e_ii,
                              logic e_tr, logic [31:0] e_ir, logic [15:0] e_cnt);
    vec_t x;
    x.v = v; x.ti = ti; x.ii = ii; x.tr = tr; x.ir = ir;
    x.mr = mr; x.wr = wr; x.fl = fl;
    x.e_rdy = e_rdy; x.e_ti = e_ti; x.e_ii = e_ii;
    x.e_tr = e_tr; x.e_ir = e_ir; x.e_cnt = e_cnt;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp, input int tag);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic ti, input logic [31:0] ii,
                       input logic tr, input logic [31:0] ir, input logic mr,
                       input logic [4:0] wr, input logic fl);
    fe.if_valid   = v;
    fe.if_type_i  = ti;
    fe.if_instr_i = ii;
    fe.if_type_r  = tr;
    fe.if_instr_r = ir;
    ex_memread    = mr;
    ex_write_reg  = wr;
    flush         = fl;
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0, -1);
    end else begin
      e = sb.pop_front();
      chk("id_type_i", {31'd0, id_type_i}, {31'd0, e.ti}, e.tag);
      chk("id_type_r", {31'd0, id_type_r}, {31'd0, e.tr}, e.tag);
      if (e.ti) chk("id_instr_i", id_instr_i, e.ii, e.tag);
      if (e.tr) chk("id_instr_r", id_instr_r, e.ir, e.tag);
      chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, e.cnt}, e.tag);
    end
  endtask

  // One cycle: drive at negedge, check if_ready, queue the expected result,
  // then compare registered outputs just after the rising edge.
  task automatic step(input vec_t x, input int tag);
    exp_t e;
    @(negedge clk);
    drive(x.v, x.ti, x.ii, x.tr, x.ir, x.mr, x.wr, x.fl);
    #1;
    chk("if_ready", {31'd0, fe.if_ready}, {31'd0, x.e_rdy}, tag);
    e.ti = x.e_ti; e.tr = x.e_tr; e.ii = x.e_ii; e.ir = x.e_ir;
    e.cnt = x.e_cnt; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    exp_t e;
    btnc_i = 1'b1;
    drive(1'b1, 1'b1, P_I, 1'b1, P_R, 1'b0, 5'd0, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_if_ready", {31'd0, fe.if_ready}, 32'd0, 100);
    e = '{ti: 1'b0, tr: 1'b0, ii: 32'd0, ir: 32'd0, cnt: 16'd0, tag: 100};
    sb.push_back(e);
    pop_check();
    chk("reset_instr_i", id_instr_i, 32'd0, 100);
    chk("reset_instr_r", id_instr_r, 32'd0, 100);
    btnc_i = 1'b0;

    // v  ti ii  tr ir  mr wr fl | rdy ti ii tr ir cnt
    vecs.push_back(mk(1,1,P_I,  1,P_R,  0,0,0, 1,1,P_I,  1,P_R,  0)); // independent
    vecs.push_back(mk(1,1,P_I,  1,RAW_R,0,0,0, 1,1,P_I,  0,0,    1)); // RAW split
    vecs.push_back(mk(1,1,P_I,  1,P_R,  1,2,0, 0,0,0,    0,0,    2)); // lw feeds held R
    vecs.push_back(mk(1,1,P_I,  1,P_R,  0,0,0, 0,0,0,    1,RAW_R,2)); // held R issues
    vecs.push_back(mk(1,1,P_I,  1,P_R,  1,5,0, 0,0,0,    0,0,    3)); // load-use in RUN
    vecs.push_back(mk(1,1,P_I,  1,P_R,  0,0,0, 1,1,P_I,  1,P_R,  3)); // resolves
    vecs.push_back(mk(1,1,WAW_I,1,WAW_R,0,0,0, 1,1,WAW_I,0,0,    4)); // WAW split
    vecs.push_back(mk(1,1,P_I,  1,P_R,  0,0,0, 0,0,0,    1,WAW_R,4)); // then R
    vecs.push_back(mk(1,1,P_I,  1,RAW_R,0,0,0, 1,1,P_I,  0,0,    5)); // split again
    vecs.push_back(mk(1,1,P_I,  1,P_R,  1,2,1, 0,0,0,    0,0,    5)); // flush in SPLIT
    vecs.push_back(mk(1,1,P_I,  1,P_R,  0,0,0, 1,1,P_I,  1,P_R,  5)); // back in RUN
    vecs.push_back(mk(0,1,P_I,  1,P_R,  0,0,0, 0,0,0,    0,0,    5)); // no valid
    vecs.push_back(mk(1,1,P_I,  1,P_R,  1,5,1, 0,0,0,    0,0,    5)); // flush beats load-use
    vecs.push_back(mk(1,1,P_I,  0,RAW_R,0,0,0, 1,1,P_I,  0,0,    5)); // empty R slot
    vecs.push_back(mk(1,1,32'h0,1,32'h00000820,1,0,0, 1,1,32'h0,1,32'h00000820,5)); // $0
    vecs.push_back(mk(1,1,P_I,  1,WAW_R,1,1,0, 0,0,0,    0,0,    6)); // load-use on I rs
    vecs.push_back(mk(1,1,32'hAC450000,1,WAW_R,1,5,0, 0,0,0, 0,0, 7)); // sw reads rt
    vecs.push_back(mk(1,1,32'h8C250000,1,WAW_R,1,5,0, 1,1,32'h8C250000,1,WAW_R,7)); // lw rt not a source

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // Reset in the middle of SPLIT discards the held instruction
    step(mk(1,1,P_I,1,RAW_R,0,0,0, 1,1,P_I,0,0,8), 200);
    @(negedge clk);
    btnc_i = 1'b1;
    drive(1'b1, 1'b1, P_I, 1'b1, P_R, 1'b0, 5'd0, 1'b0);
    #1;
    chk("rst_split_if_ready", {31'd0, fe.if_ready}, 32'd0, 201);
    e = '{ti: 1'b0, tr: 1'b0, ii: 32'd0, ir: 32'd0, cnt: 16'd0, tag: 201};
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_check();
    chk("rst_split_instr_i", id_instr_i, 32'd0, 201);
    chk("rst_split_instr_r", id_instr_r, 32'd0, 201);
    @(negedge clk);
    btnc_i = 1'b0;
    step(mk(1,1,P_I,1,P_R,0,0,0, 1,1,P_I,1,P_R,0), 202);

    // Counter saturation under sustained load-use
    @(negedge clk);
    drive(1'b1, 1'b1, P_I, 1'b1, P_R, 1'b1, 5'd5, 1'b0);
    repeat (65535) @(posedge clk);
    #1;
    chk("sat_reach", {16'd0, stall_cnt}, 32'h0000FFFF, 300);
    step(mk(1,1,P_I,1,P_R,1,5,0, 0,0,0,0,0,16'hFFFF), 301);
    step(mk(1,1,P_I,1,P_R,1,5,0, 0,0,0,0,0,16'hFFFF), 302);
    step(mk(1,1,P_I,1,P_R,0,0,0, 1,1,P_I,1,P_R,16'hFFFF), 303);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
